// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game controller.
//   state_e    : FSM state encoding, which is also visible on the state output.
//   SCORE_MAX  : ceiling for the 8-bit score.
//   CD_CNT_W   : width of the pre-round countdown counter.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_OVER      = 3'd4
    } state_e;

    localparam logic [7:0] SCORE_MAX = 8'd255;
    localparam int         CD_CNT_W  = 28;

endpackage : game_pkg

// File: rtl/game_ctrl_rise_edge.sv
// -----------------------------------------------------------------------------
// rise_edge
// Registered rising-edge detector. pulse_o is high for exactly one cycle,
// one cycle after d_i is first sampled high following a low sample.
//   clk     : clock, posedge
//   reset   : synchronous active-high reset, clears history and pulse
//   d_i     : level input
//   pulse_o : one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= d_i;
            pulse_q <= d_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule : rise_edge

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Round controller for the catch game: start/pause/score handling, pre-round
// countdown and round time limit, driving the external round timer.
//   clk         : sole clock, posedge
//   reset       : synchronous active-high reset
//   start       : level button, rising edge starts/restarts a round
//   pause       : level button, rising edge toggles pause
//   catch_evt   : level, rising edge = target caught
//   penalty_evt : level, rising edge = penalty
//   elapsed     : BCD elapsed round time from the round timer
//   timer_reset : round timer reset
//   timer_halt  : round timer halt
//   points      : current score
//   game_over   : high while the round is over
//   state       : current FSM state code
// -----------------------------------------------------------------------------
module game_ctrl
    import game_pkg::*;
#(
    parameter logic [19:0] TIME_LIMIT_BCD   = 20'h00600,
    parameter int unsigned COUNTDOWN_CYCLES = 195000000,
    parameter logic [7:0]  CATCH_PTS        = 8'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        catch_evt,
    input  logic        penalty_evt,
    input  logic [19:0] elapsed,
    output logic        timer_reset,
    output logic        timer_halt,
    output logic [7:0]  points,
    output logic        game_over,
    output logic [2:0]  state
);

    localparam logic [CD_CNT_W-1:0] CD_LAST = CD_CNT_W'(COUNTDOWN_CYCLES - 1);

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? SCORE_MAX : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] a);
        return (a == 8'd0) ? 8'd0 : a - 8'd1;
    endfunction

    // Edge detection: everything downstream sees only one-cycle pulses.
    logic start_p, pause_p, catch_p, pen_p;

    rise_edge u_start_edge   (.clk(clk), .reset(reset), .d_i(start),       .pulse_o(start_p));
    rise_edge u_pause_edge   (.clk(clk), .reset(reset), .d_i(pause),       .pulse_o(pause_p));
    rise_edge u_catch_edge   (.clk(clk), .reset(reset), .d_i(catch_evt),   .pulse_o(catch_p));
    rise_edge u_penalty_edge (.clk(clk), .reset(reset), .d_i(penalty_evt), .pulse_o(pen_p));

    state_e              state_q, state_d;
    logic [CD_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]          points_q, points_d;
    logic                timer_reset_q, timer_reset_d;
    logic                timer_halt_q, timer_halt_d;
    logic                game_over_q, game_over_d;
    logic                limit_hit;

    // BCD digits compare correctly as a plain unsigned number.
    assign limit_hit = (elapsed >= TIME_LIMIT_BCD);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        points_d = points_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_p) begin
                    state_d  = ST_COUNTDOWN;
                    cnt_d    = '0;
                    points_d = 8'd0;
                end
            end
            ST_COUNTDOWN: begin
                if (cnt_q == CD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Time limit wins over pause and freezes the score.
                if (limit_hit) begin
                    state_d = ST_OVER;
                end else begin
                    if (pause_p) begin
                        state_d = ST_PAUSED;
                    end
                    // Coincident catch and penalty cancel out.
                    if (catch_p && !pen_p) begin
                        points_d = sat_add(points_q, CATCH_PTS);
                    end else if (pen_p && !catch_p) begin
                        points_d = sat_dec(points_q);
                    end
                end
            end
            ST_PAUSED: begin
                if (pause_p) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together
    // with the state itself.
    always_comb begin
        timer_reset_d = 1'b0;
        timer_halt_d  = 1'b1;
        game_over_d   = 1'b0;
        case (state_d)
            ST_IDLE, ST_COUNTDOWN: begin
                timer_reset_d = 1'b1;
                timer_halt_d  = 1'b1;
            end
            ST_RUN: begin
                timer_halt_d = 1'b0;
            end
            ST_PAUSED: begin
                timer_halt_d = 1'b1;
            end
            ST_OVER: begin
                timer_halt_d = 1'b1;
                game_over_d  = 1'b1;
            end
            default: begin
                timer_reset_d = 1'b1;
                timer_halt_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            points_q      <= 8'd0;
            timer_reset_q <= 1'b1;
            timer_halt_q  <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            points_q      <= points_d;
            timer_reset_q <= timer_reset_d;
            timer_halt_q  <= timer_halt_d;
            game_over_q   <= game_over_d;
        end
    end

    assign timer_reset = timer_reset_q;
    assign timer_halt  = timer_halt_q;
    assign points      = points_q;
    assign game_over   = game_over_q;
    assign state       = state_q;

endmodule : game_ctrl
